axi_slave: RTL and testbench

Single-beat, AXI4-Lite-style memory-mapped slave backed by a small internal word-addressed register array. Accepts one write (address and data on independent channels, then a write response) and one read (address, then data) at a time. Sits at the leaf of the bus fabric as a scratch/config register target.

---
 rtl/axi_slave.sv | 134 +++++++++++++
 tb/tb_axi_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave.sv
// Single-beat AXI4-Lite-style register slave: DEPTH x 32-bit word array,
// one outstanding write and one outstanding read, paths run concurrently.
module axi_slave #(
  parameter int DEPTH = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] AWADDR,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic        WVALID,
  input  logic [31:0] WDATA,
  output logic        WREADY,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  logic [31:0]   mem_q [DEPTH];

  logic          awready_q, awready_d;
  logic          wready_q,  wready_d;
  logic          aw_done_q, w_done_q;
  logic [IW-1:0] awaddr_q;
  logic [31:0]   wdata_q;
  logic          bvalid_q;

  rstate_t       rstate_q, rstate_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          aw_hs, w_hs, b_hs, commit;
  logic [IW-1:0] wr_idx;
  logic [31:0]   wr_data;

  // Address bits outside the word index are don't-care (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[31:IW+2], AWADDR[1:0], ARADDR[31:IW+2], ARADDR[1:0]};

  // ---------------- write path ----------------
  assign aw_hs  = AWVALID & awready_q;
  assign w_hs   = WVALID  & wready_q;
  assign b_hs   = bvalid_q & BREADY;
  // Commit on the edge where the second of AW/W lands (or both together).
  assign commit = (aw_done_q | aw_hs) & (w_done_q | w_hs) & ~bvalid_q;

  assign wr_idx  = aw_hs ? AWADDR[IW+1:2] : awaddr_q;
  assign wr_data = w_hs  ? WDATA          : wdata_q;

  always_comb begin
    awready_d = AWVALID & ~awready_q & ~aw_done_q & ~bvalid_q;
    wready_d  = WVALID  & ~wready_q  & ~w_done_q  & ~bvalid_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      bvalid_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      if (b_hs) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        bvalid_q  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_done_q <= 1'b1;
          awaddr_q  <= AWADDR[IW+1:2];
        end
        if (w_hs) begin
          w_done_q <= 1'b1;
          wdata_q  <= WDATA;
        end
        if (commit) begin
          mem_q[wr_idx] <= wr_data;
          bvalid_q      <= 1'b1;
        end
      end
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: if (ARVALID) rstate_d = R_ADDR;
      R_ADDR: begin
        // mem_q is sampled pre-edge, so a same-edge write returns old data.
        if (ARVALID) begin
          rdata_d  = mem_q[ARADDR[IW+1:2]];
          rstate_d = R_DATA;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: if (RREADY) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign ARREADY = (rstate_q == R_ADDR);
  assign RVALID  = (rstate_q == R_DATA);
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_slave.sv
// Directed bench for axi_slave: vector table of single writes/reads plus
// hand-timed sequences for ordering, backpressure, same-edge and reset cases.
module tb_axi_slave;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] AWADDR = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic        WVALID = 1'b0;
  logic [31:0] WDATA = '0;
  logic        WREADY;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [31:0] ARADDR = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  axi_slave #(.DEPTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    AWADDR = addr; WDATA = data; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    step();
    chk("wr_awready_up", AWREADY, 1);
    chk("wr_wready_up", WREADY, 1);
    chk("wr_bvalid_early", BVALID, 0);
    step();
    chk("wr_bvalid", BVALID, 1);
    chk("wr_awready_drop", AWREADY, 0);
    AWVALID = 1'b0; WVALID = 1'b0;
    step();
    chk("wr_bvalid_clear", BVALID, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string nm);
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    step();
    chk({nm, "_arready"}, ARREADY, 1);
    chk({nm, "_rvalid_early"}, RVALID, 0);
    step();
    chk({nm, "_rvalid"}, RVALID, 1);
    chk({nm, "_rdata"}, RDATA, exp);
    chk({nm, "_arready_drop"}, ARREADY, 0);
    ARVALID = 1'b0;
    step();
    chk({nm, "_rvalid_clear"}, RVALID, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h0000_0044, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 32'h0000_0007, 32'hDEAD_BEEF};
    vecs[6] = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D};
    vecs[7] = '{1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 32'h0000_0040, 32'h55AA_55AA};
    vecs[9] = '{1'b0, 32'h0000_0002, 32'h55AA_55AA};

    // Reset state
    #12;
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rdata", RDATA, 0);
    step();
    ARESETn = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end

    // AW before W, with a read of the same word landing on the commit edge
    AWADDR = 32'h8; AWVALID = 1'b1; BREADY = 1'b0;
    step();
    chk("awfirst_awready", AWREADY, 1);
    chk("awfirst_wready", WREADY, 0);
    step();
    chk("awfirst_awready_drop", AWREADY, 0);
    chk("awfirst_no_b", BVALID, 0);
    AWVALID = 1'b0; WDATA = 32'hA5A5_A5A5; WVALID = 1'b1;
    ARADDR = 32'h8; ARVALID = 1'b1; RREADY = 1'b0;
    step();
    chk("awfirst_wready", WREADY, 1);
    chk("awfirst_arready", ARREADY, 1);
    chk("awfirst_no_b2", BVALID, 0);
    step();
    chk("awfirst_bvalid", BVALID, 1);
    chk("sameedge_rvalid", RVALID, 1);
    chk("sameedge_old_data", RDATA, 32'h0);
    WVALID = 1'b0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;
    step();
    chk("awfirst_bclear", BVALID, 0);
    chk("sameedge_rclear", RVALID, 0);
    do_read(32'h8, 32'hA5A5_A5A5, "awfirst_rd");

    // W before AW
    WDATA = 32'h0BAD_F00D; WVALID = 1'b1; BREADY = 1'b1;
    step();
    chk("wfirst_wready", WREADY, 1);
    chk("wfirst_awready", AWREADY, 0);
    step();
    chk("wfirst_no_b", BVALID, 0);
    chk("wfirst_wready_drop", WREADY, 0);
    WVALID = 1'b0; AWADDR = 32'hC; AWVALID = 1'b1;
    step();
    chk("wfirst_awready", AWREADY, 1);
    chk("wfirst_no_b2", BVALID, 0);
    step();
    chk("wfirst_bvalid", BVALID, 1);
    AWVALID = 1'b0;
    step();
    chk("wfirst_bclear", BVALID, 0);
    step();
    chk("wfirst_single_b", BVALID, 0);
    do_read(32'hC, 32'h0BAD_F00D, "wfirst_rd");

    // BREADY held low with a second write pending
    AWADDR = 32'h10; WDATA = 32'h1111_2222; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    step();
    step();
    chk("bhold_bvalid", BVALID, 1);
    AWADDR = 32'h14; WDATA = 32'h3333_4444;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bhold_bvalid_c%0d", i), BVALID, 1);
      chk($sformatf("bhold_awready_c%0d", i), AWREADY, 0);
      chk($sformatf("bhold_wready_c%0d", i), WREADY, 0);
    end
    BREADY = 1'b1;
    step();
    chk("bhold_bclear", BVALID, 0);
    chk("bhold_awready_still0", AWREADY, 0);
    step();
    chk("bhold2_awready", AWREADY, 1);
    chk("bhold2_wready", WREADY, 1);
    step();
    chk("bhold2_bvalid", BVALID, 1);
    AWVALID = 1'b0; WVALID = 1'b0;
    step();
    chk("bhold2_bclear", BVALID, 0);
    do_read(32'h10, 32'h1111_2222, "bhold_rd1");

    // RREADY held low, ARVALID kept high to show no new AR is taken
    ARADDR = 32'h14; ARVALID = 1'b1; RREADY = 1'b0;
    step();
    chk("rhold_arready", ARREADY, 1);
    step();
    chk("rhold_rvalid", RVALID, 1);
    chk("rhold_rdata", RDATA, 32'h3333_4444);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rhold_rvalid_c%0d", i), RVALID, 1);
      chk($sformatf("rhold_rdata_c%0d", i), RDATA, 32'h3333_4444);
      chk($sformatf("rhold_arready_c%0d", i), ARREADY, 0);
    end
    RREADY = 1'b1;
    step();
    chk("rhold_rclear", RVALID, 0);
    chk("rhold_arready_still0", ARREADY, 0);
    ARADDR = 32'h10;
    step();
    chk("rhold2_arready", ARREADY, 1);
    step();
    chk("rhold2_rdata", RDATA, 32'h1111_2222);
    ARVALID = 1'b0;
    step();
    chk("rhold2_rclear", RVALID, 0);

    // Reset in the middle of a write, before the handshake
    AWADDR = 32'h1C; WDATA = 32'h7777_7777; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    step();
    chk("midrst_awready_pre", AWREADY, 1);
    #1 ARESETn = 1'b0;
    #1;
    chk("midrst_awready", AWREADY, 0);
    chk("midrst_wready", WREADY, 0);
    chk("midrst_bvalid", BVALID, 0);
    chk("midrst_rdata", RDATA, 0);
    AWVALID = 1'b0; WVALID = 1'b0;
    step();
    ARESETn = 1'b1;
    step();
    do_read(32'h1C, 32'h0, "midrst_rd1c");
    do_read(32'h0, 32'h0, "midrst_rd0");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
